serial_add_scheduler: RTL and testbench
=======================================

Name: serial_add_scheduler

Overview:
- Shares one bit-serial adder between NREQ requesters under round-robin arbitration.
- Each requester presents two WIDTH-bit operands and a request. The block grants one requester, captures its operands, and runs the add LSB-first one bit per cycle. It then returns a WIDTH+1-bit sum tagged with the winner's index.
- Sits between the operand-producing clients and the shared serial-add datapath. The datapath (one full adder plus carry flop) is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits (>= 2).
- IDW, $clog2(NREQ), width of requester index (localparam, not overridable).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req, input, NREQ, per-requester request level.
- op_a, input, NREQ*WIDTH, operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- op_b, input, NREQ*WIDTH, operand B, same packing.
- grant, output, NREQ, one-hot; high for exactly the LOAD cycle of the winner.
- busy, output, 1, high in LOAD, RUN and DONE.
- done, output, 1, one-cycle pulse when the result is valid.
- done_id, output, IDW, index of the requester whose result is in sum.
- sum, output, WIDTH+1, {carry_out, result}.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; grant=0, busy=0, done=0, done_id=0, sum=0.
  - Shift registers, carry and bit counter cleared.
  - last_winner=NREQ-1, so requester 0 has first priority.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - req is sampled each edge; it is ignored in every other state.
  - If req != 0, the winner is the first set bit searching upward from last_winner+1, wrapping modulo NREQ. Next state is LOAD.
  - If req == 0, stay in IDLE.
- LOAD (1 cycle):
  - grant[winner]=1.
  - At the closing edge: A_sh <= op_a[winner], B_sh <= op_b[winner], carry <= 0, bitcnt <= 0, last_winner <= winner. Next state is RUN.
- RUN (exactly WIDTH cycles), each edge:
  - s = A_sh[0] ^ B_sh[0] ^ carry.
  - carry <= majority(A_sh[0], B_sh[0], carry).
  - A_sh and B_sh shift right; s shifts into the MSB of the result shift register.
  - bitcnt increments. At the edge where bitcnt == WIDTH-1, go to DONE.
- DONE (1 cycle):
  - sum = {carry, result}, done=1, done_id=last_winner.
  - sum and done_id are registered on entry and hold until the next DONE.
  - Next state is IDLE.
- Latency: req sampled at edge k -> grant high in cycle k+1 -> done high in cycle k+WIDTH+2.
- Occupancy: WIDTH+3 cycles per operation, including the IDLE arbitration cycle.
- Handshake:
  - A requester keeps req high until it sees grant, and must hold op_a/op_b stable through the grant cycle.
  - req still high in the IDLE cycle after DONE is treated as a new request.
  - Dropping req before grant withdraws the request with no side effects.
- Arithmetic: unsigned. Carry out is in sum[WIDTH]; no overflow flag. Operands of requesters that do not win are never read.
- Simultaneous events:
  - Multiple reqs in the same IDLE cycle are resolved purely by the round-robin pointer.
  - A req arriving during LOAD, RUN or DONE waits and is sampled at the next IDLE.
- Reset mid-operation: aborts immediately. No done pulse, sum cleared, pointer reset to NREQ-1.
- grant is never high outside LOAD; at most one grant bit is set at any time.

Test Plan:
- Single add: req=4'b0001, op_a[0]=8'hFF, op_b[0]=8'h01 -> grant=4'b0001 one cycle later; done 10 cycles after the sampling edge; sum=9'h100, done_id=0.
- Zero and max: requester 3 adds 8'h00+8'h00 -> sum=9'h000; then 8'hFF+8'hFF -> sum=9'h1FE, done_id=3.
- All four request simultaneously and hold until granted, operands i+10 each -> grants in order 0,1,2,3, sums 20,22,24,26, each done 11 cycles apart.
- Fairness: req0 and req2 held continuously -> grant alternates 0,2,0,2; no requester is granted twice in a row while the other is waiting.
- Reset mid-RUN: assert reset_n=0 on the 4th RUN cycle of an 8'h55+8'hAA add -> outputs return to 0 with no done pulse. After release, a req1 add of 8'h55+8'hAA gives sum=9'h0FF, done_id=1.
- Late request: req1 rises during RUN of requester 0 -> no grant until after DONE; req1 sampled in the following IDLE and granted the cycle after.

Source files
------------

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler that shares one bit-serial adder (full adder + carry flop)
// between NREQ requesters. Sums are returned LSB-first assembled, tagged with the winner index.
module serial_add_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [WIDTH:0]          sum
);

    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     last_winner;
    logic [IDW-1:0]     nxt_winner;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   res_sh;
    logic [WIDTH-1:0]   res_nx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               carry;
    logic               carry_nx;
    logic               s_bit;
    logic [CNTW-1:0]    bitcnt;

    // First set request strictly after the previous winner, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        int             t;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            t = int'(last) + i;
            if (t >= NREQ) t = t - NREQ;
            idx = IDW'(t);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign nxt_winner = rr_pick(req, last_winner);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                a_sel = op_a[i*WIDTH +: WIDTH];
                b_sel = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Shared serial datapath: one full adder, the carry flop holds the ripple between bits.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign res_nx   = {s_bit, res_sh};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            winner      <= '0;
            last_winner <= IDW'(NREQ-1);
            grant       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= '0;
            sum         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            carry       <= 1'b0;
            bitcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner <= nxt_winner;
                        grant  <= {{(NREQ-1){1'b0}}, 1'b1} << nxt_winner;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    grant       <= '0;
                    a_sh        <= a_sel;
                    b_sh        <= b_sel;
                    carry       <= 1'b0;
                    bitcnt      <= '0;
                    last_winner <= winner;
                    state       <= RUN;
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_nx;
                    res_sh <= res_nx[WIDTH-1:1];
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == CNTW'(WIDTH-1)) begin
                        sum     <= {carry_nx, res_nx};
                        done_id <= last_winner;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler: table of single adds plus arbitration,
// fairness, mid-run reset and late-request sequences.
module tb_serial_add_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH:0]        sum;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op_a(op_a), .op_b(op_b),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id), .sum(sum)
    );

    typedef struct {
        int             id;
        logic [7:0]     a;
        logic [7:0]     b;
        logic [8:0]     s;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
        op_a[id*WIDTH +: WIDTH] = a;
        op_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_grant(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 30);
        if (grant == '0) timeout(name);
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 30);
        if (!done) timeout(name);
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input string name);
        int n;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        set_op(id, a, b);
        req = oh;
        wait_grant({name, "_grant_to"}, n);
        chk({name, "_grant"}, grant, oh);
        chk({name, "_grant_lat"}, n, 1);
        req = '0;
        wait_done({name, "_done_to"}, n);
        chk({name, "_done_lat"}, n, WIDTH+1);
        chk({name, "_sum"}, sum, exp);
        chk({name, "_id"}, done_id, id);
        tick();
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_busy_off"}, busy, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        int n, ng, nd;
        int g_ord[4];
        int d_cyc[4];
        logic [8:0] d_sum[4];
        int d_id[4];
        int t;

        vecs[0] = '{id: 0, a: 8'hFF, b: 8'h01, s: 9'h100};
        vecs[1] = '{id: 3, a: 8'h00, b: 8'h00, s: 9'h000};
        vecs[2] = '{id: 3, a: 8'hFF, b: 8'hFF, s: 9'h1FE};
        vecs[3] = '{id: 1, a: 8'h55, b: 8'hAA, s: 9'h0FF};
        vecs[4] = '{id: 2, a: 8'h80, b: 8'h80, s: 9'h100};
        vecs[5] = '{id: 0, a: 8'h12, b: 8'h34, s: 9'h046};

        reset_n = 1'b0;
        req     = '0;
        op_a    = '0;
        op_b    = '0;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_sum", sum, 0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++)
            do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].s, $sformatf("vec%0d", v));

        // All four together after reset: pointer starts at NREQ-1 so order is 0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i+10), 8'(i+10));
        req = 4'hF;
        ng = 0;
        nd = 0;
        t  = 0;
        while (nd < 4 && t < 80) begin
            tick();
            t++;
            if (grant != '0) begin
                if (ng < 4) g_ord[ng] = oh2idx(grant);
                ng++;
                req = req & ~grant;
            end
            if (done && nd < 4) begin
                d_sum[nd] = sum;
                d_id[nd]  = done_id;
                d_cyc[nd] = t;
                nd++;
            end
        end
        if (nd < 4) timeout("all4_done");
        chk("all4_ngrants", ng, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4_order%0d", i), g_ord[i], i);
            chk($sformatf("all4_sum%0d", i), d_sum[i], 2*(i+10));
            chk($sformatf("all4_id%0d", i), d_id[i], i);
            if (i > 0) chk($sformatf("all4_gap%0d", i), d_cyc[i] - d_cyc[i-1], WIDTH+3);
        end
        tick();

        // Fairness: 0 and 2 held continuously must alternate.
        set_op(0, 8'h01, 8'h02);
        set_op(2, 8'h03, 8'h04);
        req = 4'b0101;
        ng = 0;
        t  = 0;
        while (ng < 4 && t < 80) begin
            tick();
            t++;
            if (grant != '0) begin
                g_ord[ng] = oh2idx(grant);
                ng++;
            end
        end
        req = '0;
        if (ng < 4) timeout("fair_grants");
        chk("fair_g0", g_ord[0], 0);
        chk("fair_g1", g_ord[1], 2);
        chk("fair_g2", g_ord[2], 0);
        chk("fair_g3", g_ord[3], 2);
        wait_done("fair_done_to", n);
        chk("fair_sum", sum, 9'h007);
        tick();

        // Reset on the 4th RUN cycle aborts with no done pulse.
        set_op(0, 8'h55, 8'hAA);
        req = 4'b0001;
        wait_grant("rst_run_grant_to", n);
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_run_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_run_busy", busy, 0);
        chk("rst_run_grant", grant, 0);
        chk("rst_run_sum", sum, 0);
        chk("rst_run_done_id", done_id, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 2) reset_n = 1'b1;
            chk($sformatf("rst_run_nodone%0d", i), done, 0);
        end
        do_op(1, 8'h55, 8'hAA, 9'h0FF, "rst_after");

        // Late request during RUN waits for the next IDLE.
        set_op(0, 8'h0F, 8'h01);
        req = 4'b0001;
        wait_grant("late_grant0_to", n);
        req = '0;
        tick();
        tick();
        set_op(1, 8'h03, 8'h04);
        req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
            if (!done) chk($sformatf("late_nogrant%0d", n), grant, 0);
        end while (!done && n < 30);
        if (!done) timeout("late_done0_to");
        chk("late_sum0", sum, 9'h010);
        chk("late_id0", done_id, 0);
        tick();
        chk("late_idle_nogrant", grant, 0);
        tick();
        chk("late_grant1", grant, 4'b0010);
        req = '0;
        wait_done("late_done1_to", n);
        chk("late_sum1", sum, 9'h007);
        chk("late_id1", done_id, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
